// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run-control sequencer that sits between a host and the core.
// It loads instruction memory through a valid/ready port while holding the core
// in reset, then releases the core for free-run or single-step execution. It
// gates the core clock enable, counts executed cycles, and stops on a halt
// instruction, a cycle limit or a user halt.
//
// Ports
//   clk, reset                        clock, asynchronous active-high reset
//   load_valid/load_ready             imem load handshake (ready only in IDLE)
//   load_addr/load_data               imem word address / instruction word
//   imem_we/imem_waddr/imem_wdata     registered imem write port
//   cmd_run/cmd_step/cmd_halt         one-cycle command pulses (halt > step > run)
//   cycle_limit                       max executed cycles per run, 0 = unlimited
//   pc_in/instruction_in              current core pc and fetched instruction
//   core_reset/core_clk_en            core reset and clock enable
//   state/done/halt_cause             sequencer status
//   retired                           executed-cycle count since last RSTSEQ
//   halt_pc                           pc_in captured on entry to DONE or PAUSE
module core_run_ctrl #(
  parameter int unsigned IMEM_AW    = 8,
  parameter int unsigned RST_CYCLES = 2,
  parameter logic [31:0] HALT_INSN  = 32'h0000_0073
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [IMEM_AW-1:0] load_addr,
  input  logic [31:0]        load_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  input  logic               cmd_run,
  input  logic               cmd_step,
  input  logic               cmd_halt,
  input  logic [31:0]        cycle_limit,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        instruction_in,
  output logic               core_reset,
  output logic               core_clk_en,
  output logic [2:0]         state,
  output logic               done,
  output logic [1:0]         halt_cause,
  output logic [31:0]        retired,
  output logic [31:0]        halt_pc
);

  localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RSTSEQ = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_PAUSE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_INSN  = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT = 2'd2;
  localparam logic [1:0] CAUSE_USER  = 2'd3;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_rst_cnt;
  logic               r_mode_step;
  logic               r_core_reset;
  logic               r_done;
  logic [1:0]         r_halt_cause;
  logic [31:0]        r_retired;
  logic [31:0]        r_halt_pc;
  logic               r_imem_we;
  logic [IMEM_AW-1:0] r_imem_waddr;
  logic [31:0]        r_imem_wdata;

  logic               w_hit;
  logic               w_lim;
  logic               w_start;
  logic               w_clk_en;
  logic               w_load_ready;
  logic [1:0]         w_cause_nxt;
  logic               w_rst_last;

  // Stop conditions evaluated against the instruction about to execute.
  assign w_hit      = (instruction_in == HALT_INSN);
  assign w_lim      = (cycle_limit != 32'd0) && (r_retired == cycle_limit);
  assign w_rst_last = (r_rst_cnt == CNT_W'(RST_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; a pending halt masks step/run.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!cmd_halt && (cmd_step || cmd_run)) w_next = S_RSTSEQ;
      end
      S_RSTSEQ: begin
        if (cmd_halt)        w_next = S_IDLE;
        else if (w_rst_last) w_next = r_mode_step ? S_STEP : S_RUN;
      end
      S_RUN: begin
        if (w_hit || w_lim) w_next = S_DONE;
        else if (cmd_halt)  w_next = S_PAUSE;
      end
      S_STEP: begin
        if (w_hit || w_lim) w_next = S_DONE;
        else                w_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (cmd_halt)      w_next = S_IDLE;
        else if (cmd_step) w_next = S_STEP;
        else if (cmd_run)  w_next = S_RUN;
      end
      S_DONE: begin
        if (cmd_halt)                 w_next = S_IDLE;
        else if (cmd_step || cmd_run) w_next = S_RSTSEQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Combinational outputs and per-transition side effects.
  always_comb begin
    w_load_ready = 1'b0;
    w_clk_en     = 1'b0;
    w_start      = 1'b0;
    w_cause_nxt  = r_halt_cause;
    case (r_state)
      S_IDLE: begin
        w_load_ready = 1'b1;
        if (w_next == S_RSTSEQ) begin
          w_start     = 1'b1;
          w_cause_nxt = CAUSE_NONE;
        end
      end
      S_RUN: begin
        w_clk_en = !w_hit && !w_lim && !cmd_halt;
        if (w_hit)         w_cause_nxt = CAUSE_INSN;
        else if (w_lim)    w_cause_nxt = CAUSE_LIMIT;
        else if (cmd_halt) w_cause_nxt = CAUSE_USER;
      end
      S_STEP: begin
        // A halt in STEP suppresses the step but leaves the cause untouched.
        w_clk_en = !w_hit && !w_lim && !cmd_halt;
        if (w_hit)      w_cause_nxt = CAUSE_INSN;
        else if (w_lim) w_cause_nxt = CAUSE_LIMIT;
      end
      S_DONE: begin
        if (w_next == S_RSTSEQ) begin
          w_start     = 1'b1;
          w_cause_nxt = CAUSE_NONE;
        end else if (w_next == S_IDLE) begin
          w_cause_nxt = CAUSE_NONE;
        end
      end
      default: ;
    endcase
  end

  // Registered status, counters and core control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_cnt    <= '0;
      r_mode_step  <= 1'b0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_halt_cause <= CAUSE_NONE;
      r_retired    <= 32'd0;
      r_halt_pc    <= 32'd0;
    end else begin
      r_rst_cnt    <= ((r_state == S_RSTSEQ) && (w_next == S_RSTSEQ)) ?
                      r_rst_cnt + CNT_W'(1) : '0;
      if (w_start) r_mode_step <= cmd_step;
      r_core_reset <= (w_next == S_IDLE) || (w_next == S_RSTSEQ);
      r_done       <= (w_next == S_DONE);
      r_halt_cause <= w_cause_nxt;
      if (w_start)       r_retired <= 32'd0;
      else if (w_clk_en) r_retired <= r_retired + 32'd1;
      if (((w_next == S_DONE) && (r_state != S_DONE)) ||
          ((w_next == S_PAUSE) && (r_state != S_PAUSE)))
        r_halt_pc <= pc_in;
    end
  end

  // One-cycle imem write strobe per accepted load word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_imem_we    <= 1'b0;
      r_imem_waddr <= '0;
      r_imem_wdata <= 32'd0;
    end else begin
      r_imem_we <= load_valid && w_load_ready;
      if (load_valid && w_load_ready) begin
        r_imem_waddr <= load_addr;
        r_imem_wdata <= load_data;
      end
    end
  end

  assign load_ready  = w_load_ready;
  assign core_clk_en = w_clk_en;
  assign imem_we     = r_imem_we;
  assign imem_waddr  = r_imem_waddr;
  assign imem_wdata  = r_imem_wdata;
  assign core_reset  = r_core_reset;
  assign state       = r_state;
  assign done        = r_done;
  assign halt_cause  = r_halt_cause;
  assign retired     = r_retired;
  assign halt_pc     = r_halt_pc;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a minimal core stand-in: a pc that
// resets with core_reset and advances by 4 on each enabled clock, and an imem
// array filled from the DUT's write port.
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cmd_run, cmd_step, cmd_halt;
  logic [31:0] cycle_limit;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic        core_reset, core_clk_en;
  logic [2:0]  state;
  logic        done;
  logic [1:0]  halt_cause;
  logic [31:0] retired, halt_pc;

  logic [31:0] mem [256];
  logic        mem_clr;
  logic [31:0] pc;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  core_run_ctrl dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
    .cycle_limit(cycle_limit), .pc_in(pc_in), .instruction_in(instruction_in),
    .core_reset(core_reset), .core_clk_en(core_clk_en),
    .state(state), .done(done), .halt_cause(halt_cause),
    .retired(retired), .halt_pc(halt_pc)
  );

  // Core stand-in: imem defaults to NOP (addi x0,x0,0).
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0000_0013;
    end else if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  always @(posedge clk) begin
    if (core_reset)       pc <= 32'd0;
    else if (core_clk_en) pc <= pc + 32'd4;
  end

  assign pc_in          = pc;
  assign instruction_in = mem[pc[9:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
  endtask

  task automatic pulse_step();
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
  endtask

  task automatic pulse_halt();
    cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    tick();
    load_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset got=%b exp=1", core_reset); end
    total++; if (core_clk_en !== 1'b0) begin bad++; $display("FAIL rst_clk_en got=%b exp=0", core_clk_en); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rst_imem_we got=%b exp=0", imem_we); end
    total++; if ({done, halt_cause} !== 3'b000) begin bad++; $display("FAIL rst_done_cause got=%b exp=000", {done, halt_cause}); end
    total++; if (retired !== 32'd0 || halt_pc !== 32'd0) begin bad++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", retired, halt_pc); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL rst_load_ready got=%b exp=1", load_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load();
    load_valid = 1'b1; load_addr = 8'd0; load_data = 32'h0053_03b3;
    #1;
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL load_ready_idle got=%b exp=1", load_ready); end
    tick();
    total++; if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 8'd0, 32'h0053_03b3}) begin
      bad++; $display("FAIL load_w0 got=%b/%0d/%h exp=1/0/005303b3", imem_we, imem_waddr, imem_wdata); end
    load_addr = 8'd1; load_data = 32'h0062_8633;
    tick();
    total++; if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 8'd1, 32'h0062_8633}) begin
      bad++; $display("FAIL load_w1 got=%b/%0d/%h exp=1/1/00628633", imem_we, imem_waddr, imem_wdata); end
    load_valid = 1'b0;
    tick();
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL load_we_drop got=%b exp=0", imem_we); end
  endtask

  task automatic test_limit();
    cycle_limit = 32'd2;
    pulse_run();
    total++; if (state !== 3'd1 || core_reset !== 1'b1 || retired !== 32'd0) begin
      bad++; $display("FAIL lim_rstseq1 got=%0d/%b/%0d exp=1/1/0", state, core_reset, retired); end
    tick();
    total++; if (state !== 3'd1 || core_reset !== 1'b1) begin bad++; $display("FAIL lim_rstseq2 got=%0d/%b exp=1/1", state, core_reset); end
    tick();
    total++; if (state !== 3'd2 || core_reset !== 1'b0 || core_clk_en !== 1'b1) begin
      bad++; $display("FAIL lim_run got=%0d/%b/%b exp=2/0/1", state, core_reset, core_clk_en); end
    tick();
    tick();
    total++; if (core_clk_en !== 1'b0 || retired !== 32'd2 || pc !== 32'd8) begin
      bad++; $display("FAIL lim_stop got=%b/%0d/%0d exp=0/2/8", core_clk_en, retired, pc); end
    tick();
    total++; if ({state, done, halt_cause} !== {3'd5, 1'b1, 2'd2}) begin
      bad++; $display("FAIL lim_done got=%0d/%b/%0d exp=5/1/2", state, done, halt_cause); end
    total++; if (retired !== 32'd2 || halt_pc !== 32'd8 || core_clk_en !== 1'b0) begin
      bad++; $display("FAIL lim_final got=%0d/%0d/%b exp=2/8/0", retired, halt_pc, core_clk_en); end
  endtask

  task automatic test_halt_insn();
    int n;
    pulse_halt();
    total++; if ({state, done, halt_cause} !== {3'd0, 1'b0, 2'd0}) begin
      bad++; $display("FAIL hi_idle got=%0d/%b/%0d exp=0/0/0", state, done, halt_cause); end
    load_word(8'd2, 32'h0000_0073);
    cycle_limit = 32'd0;
    pulse_run();
    n = 0;
    while (state !== 3'd2 && n < 10) begin tick(); n++; end
    total++; if (state !== 3'd2) begin bad++; $display("FAIL hi_reach_run got=%0d exp=2", state); end
    n = 0;
    while (core_clk_en === 1'b1 && n < 20) begin tick(); n++; end
    total++; if (core_clk_en !== 1'b0 || pc !== 32'd8 || retired !== 32'd2) begin
      bad++; $display("FAIL hi_stop got=%b/%0d/%0d exp=0/8/2", core_clk_en, pc, retired); end
    tick();
    total++; if ({state, done, halt_cause} !== {3'd5, 1'b1, 2'd1} || halt_pc !== 32'd8 || retired !== 32'd2) begin
      bad++; $display("FAIL hi_done got=%0d/%b/%0d/%0d/%0d exp=5/1/1/8/2", state, done, halt_cause, halt_pc, retired); end
  endtask

  task automatic test_step();
    pulse_step();
    total++; if (state !== 3'd1 || retired !== 32'd0 || halt_cause !== 2'd0) begin
      bad++; $display("FAIL st_rstseq got=%0d/%0d/%0d exp=1/0/0", state, retired, halt_cause); end
    tick();
    tick();
    total++; if (state !== 3'd3 || core_clk_en !== 1'b1) begin bad++; $display("FAIL st_step1 got=%0d/%b exp=3/1", state, core_clk_en); end
    tick();
    total++; if (state !== 3'd4 || retired !== 32'd1 || halt_pc !== 32'd0 || core_clk_en !== 1'b0) begin
      bad++; $display("FAIL st_pause1 got=%0d/%0d/%0d/%b exp=4/1/0/0", state, retired, halt_pc, core_clk_en); end
    pulse_step();
    total++; if (state !== 3'd3 || core_clk_en !== 1'b1) begin bad++; $display("FAIL st_step2 got=%0d/%b exp=3/1", state, core_clk_en); end
    tick();
    total++; if (state !== 3'd4 || retired !== 32'd2 || halt_pc !== 32'd4 || halt_cause !== 2'd0) begin
      bad++; $display("FAIL st_pause2 got=%0d/%0d/%0d/%0d exp=4/2/4/0", state, retired, halt_pc, halt_cause); end
    pulse_step();
    total++; if (state !== 3'd3 || core_clk_en !== 1'b0) begin bad++; $display("FAIL st_step3_hit got=%0d/%b exp=3/0", state, core_clk_en); end
    tick();
    total++; if ({state, halt_cause} !== {3'd5, 2'd1} || retired !== 32'd2 || halt_pc !== 32'd8) begin
      bad++; $display("FAIL st_done got=%0d/%0d/%0d/%0d exp=5/1/2/8", state, halt_cause, retired, halt_pc); end
  endtask

  task automatic test_pause_resume();
    pulse_halt();
    load_word(8'd2, 32'h0000_0013);
    cycle_limit = 32'd0;
    pulse_run();
    tick();
    tick();
    tick();
    total++; if (state !== 3'd2 || retired !== 32'd1) begin bad++; $display("FAIL pr_run got=%0d/%0d exp=2/1", state, retired); end
    cmd_halt = 1'b1;
    #1;
    total++; if (core_clk_en !== 1'b0) begin bad++; $display("FAIL pr_halt_gate got=%b exp=0", core_clk_en); end
    tick();
    cmd_halt = 1'b0;
    total++; if ({state, halt_cause} !== {3'd4, 2'd3} || retired !== 32'd1 || halt_pc !== 32'd4) begin
      bad++; $display("FAIL pr_pause got=%0d/%0d/%0d/%0d exp=4/3/1/4", state, halt_cause, retired, halt_pc); end
    pulse_run();
    total++; if (state !== 3'd2 || core_reset !== 1'b0 || retired !== 32'd1) begin
      bad++; $display("FAIL pr_resume got=%0d/%b/%0d exp=2/0/1", state, core_reset, retired); end
    tick();
    total++; if (retired !== 32'd2) begin bad++; $display("FAIL pr_count got=%0d exp=2", retired); end
    pulse_halt();
    pulse_halt();
    total++; if (state !== 3'd0 || core_reset !== 1'b1) begin bad++; $display("FAIL pr_idle got=%0d/%b exp=0/1", state, core_reset); end
  endtask

  task automatic test_mid_reset();
    pulse_run();
    tick();
    tick();
    load_valid = 1'b1; load_addr = 8'd9; load_data = 32'hdead_beef;
    #1;
    total++; if (state !== 3'd2 || load_ready !== 1'b0) begin bad++; $display("FAIL mr_ready got=%0d/%b exp=2/0", state, load_ready); end
    tick();
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL mr_no_we got=%b exp=0", imem_we); end
    load_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++; if (state !== 3'd0 || core_reset !== 1'b1 || core_clk_en !== 1'b0 || retired !== 32'd0) begin
      bad++; $display("FAIL mr_abort got=%0d/%b/%b/%0d exp=0/1/0/0", state, core_reset, core_clk_en, retired); end
    reset = 1'b0;
    tick();
    total++; if (state !== 3'd0 || load_ready !== 1'b1) begin bad++; $display("FAIL mr_after got=%0d/%b exp=0/1", state, load_ready); end
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    load_valid = 1'b0; load_addr = 8'd0; load_data = 32'd0;
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0; cycle_limit = 32'd0;
    tick();
    tick();
    mem_clr = 1'b0;
    test_reset();
    test_load();
    test_limit();
    test_halt_insn();
    test_step();
    test_pause_resume();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
